multi_alarm_clock: RTL and testbench

Parametrised timekeeping core with seconds, minutes, hours and day-of-week counters plus `NUM_ALARMS` independent alarm slots. Each slot has its own ring/snooze state machine, ring timeout and optional day-of-week mask. It replaces the single-alarm clock datapath and sits between the button debouncers and the 7-segment display drivers. Display drivers consume the `disp_*` and `t*` outputs unchanged.

---
 rtl/multi_alarm_clock.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_multi_alarm_clock.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock
//   Timekeeping core: seconds / minutes / hours / day-of-week counters plus
//   NUM_ALARMS independent alarm slots, each with an IDLE/RINGING/SNOOZED
//   state machine, ring timeout and (optionally) a day-of-week mask.
//
//   Optional feature macro: MULTI_ALARM_DAYMASK_EN
//     defined   : each slot keeps a 7-bit day mask (bit d = fire on day d),
//                 written via dmask_wr/dmask_in while in alarm set mode.
//     undefined : no mask registers, slots fire every day, dmask_* ignored.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                1 Hz enable; time/alarm/ring/snooze counters move only on it
//   timeset, alarmset   mode levels
//   minadv, hrsadv,
//   dayadv              manual advance levels (one step per tick)
//   alarm_sel           slot being set / displayed
//   alarm_on            per-slot arm
//   dmask_wr, dmask_in  day-mask write (only with MULTI_ALARM_DAYMASK_EN)
//   snooze, dismiss     one-cycle pulses acting on every non-idle slot
//   tsec/tmin/thrs/tday current time
//   disp_min, disp_hrs  display mux (alarm in set mode, else time)
//   ringing             per-slot RINGING flag
//   buzz                registered OR of ringing
module multi_alarm_clock #(
  parameter  int NUM_ALARMS = 4,
  parameter  int SNOOZE_MIN = 9,
  parameter  int RING_SEC   = 60,
  localparam int SEL_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  timeset,
  input  logic                  alarmset,
  input  logic                  minadv,
  input  logic                  hrsadv,
  input  logic                  dayadv,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [NUM_ALARMS-1:0] alarm_on,
  input  logic                  dmask_wr,
  input  logic [6:0]            dmask_in,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic [5:0]            tsec,
  output logic [5:0]            tmin,
  output logic [4:0]            thrs,
  output logic [2:0]            tday,
  output logic [5:0]            disp_min,
  output logic [4:0]            disp_hrs,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  buzz
);

  localparam logic [11:0] SNZ_LOAD  = 12'(SNOOZE_MIN * 60);
  localparam logic [7:0]  RING_LAST = 8'(RING_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNZ
  } state_e;

  // ---------------------------------------------------------------------------
  // Time counters
  // ---------------------------------------------------------------------------
  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hrs_q, hrs_d;
  logic [2:0] day_q, day_d;

  logic run, set_mode;
  logic sec_wrap, min_wrap, hrs_wrap;
  logic min_step, hrs_step, day_step;

  always_comb begin
    run      = !timeset && !alarmset;
    set_mode = alarmset && !timeset;

    // Carries only come from the free-running seconds chain; manual
    // advances step a single field without carrying.
    sec_wrap = tick && run && (sec_q == 6'd59);
    min_wrap = sec_wrap && (min_q == 6'd59);
    hrs_wrap = min_wrap && (hrs_q == 5'd23);

    min_step = tick && !alarmset && (sec_wrap || (timeset && minadv));
    hrs_step = tick && !alarmset && (min_wrap || (timeset && hrsadv));
    day_step = tick && !alarmset && (hrs_wrap || (timeset && dayadv));

    sec_d = sec_q;
    if (tick && run) begin
      sec_d = sec_wrap ? '0 : sec_q + 6'd1;
    end
    min_d = min_q;
    if (min_step) begin
      min_d = (min_q == 6'd59) ? '0 : min_q + 6'd1;
    end
    hrs_d = hrs_q;
    if (hrs_step) begin
      hrs_d = (hrs_q == 5'd23) ? '0 : hrs_q + 5'd1;
    end
    day_d = day_q;
    if (day_step) begin
      day_d = (day_q == 3'd6) ? '0 : day_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q <= '0;
      min_q <= '0;
      hrs_q <= '0;
      day_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hrs_q <= hrs_d;
      day_q <= day_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm time registers
  // ---------------------------------------------------------------------------
  logic [5:0] alm_min_q [NUM_ALARMS];
  logic [5:0] alm_min_d [NUM_ALARMS];
  logic [4:0] alm_hrs_q [NUM_ALARMS];
  logic [4:0] alm_hrs_d [NUM_ALARMS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      alm_min_d[i] = alm_min_q[i];
      alm_hrs_d[i] = alm_hrs_q[i];
      // An out-of-range alarm_sel never equals any slot index, so it is a no-op.
      if (tick && set_mode && (alarm_sel == SEL_W'(i))) begin
        if (minadv) begin
          alm_min_d[i] = (alm_min_q[i] == 6'd59) ? '0 : alm_min_q[i] + 6'd1;
        end
        if (hrsadv) begin
          alm_hrs_d[i] = (alm_hrs_q[i] == 5'd23) ? '0 : alm_hrs_q[i] + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alm_min_q[i] <= '0;
        alm_hrs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alm_min_q[i] <= alm_min_d[i];
        alm_hrs_q[i] <= alm_hrs_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Day-of-week enable per slot (looked up at the day the wrap lands on)
  // ---------------------------------------------------------------------------
  logic [NUM_ALARMS-1:0] day_en;

`ifdef MULTI_ALARM_DAYMASK_EN
  logic [6:0] mask_q [NUM_ALARMS];
  logic [6:0] mask_d [NUM_ALARMS];

  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      mask_d[i] = mask_q[i];
      if (dmask_wr && set_mode && (alarm_sel == SEL_W'(i))) begin
        mask_d[i] = dmask_in;
      end
      day_en[i] = mask_q[i][day_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        mask_q[i] <= 7'h7F;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        mask_q[i] <= mask_d[i];
      end
    end
  end
`else
  logic unused_dmask;
  assign unused_dmask = ^{dmask_wr, dmask_in};
  assign day_en       = '1;
`endif

  // ---------------------------------------------------------------------------
  // Per-slot ring / snooze state machines
  // ---------------------------------------------------------------------------
  state_e      st_q   [NUM_ALARMS];
  state_e      st_d   [NUM_ALARMS];
  logic [7:0]  ring_q [NUM_ALARMS];
  logic [7:0]  ring_d [NUM_ALARMS];
  logic [11:0] snz_q  [NUM_ALARMS];
  logic [11:0] snz_d  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match;

  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      // Compare against the post-wrap time so the slot rings on the edge
      // that loads hh:mm:00.
      match[i] = sec_wrap && alarm_on[i] && day_en[i] &&
                 (min_d == alm_min_q[i]) && (hrs_d == alm_hrs_q[i]);

      st_d[i]   = st_q[i];
      ring_d[i] = ring_q[i];
      snz_d[i]  = snz_q[i];

      if (!alarm_on[i]) begin
        st_d[i] = S_IDLE;
      end else begin
        unique case (st_q[i])
          S_IDLE: begin
            if (match[i]) begin
              st_d[i]   = S_RING;
              ring_d[i] = '0;
            end
          end
          S_RING: begin
            if (dismiss) begin
              st_d[i] = S_IDLE;
            end else if (snooze) begin
              st_d[i]  = S_SNZ;
              snz_d[i] = SNZ_LOAD;
            end else if (tick) begin
              if (ring_q[i] == RING_LAST) begin
                st_d[i] = S_IDLE;
              end else begin
                ring_d[i] = ring_q[i] + 8'd1;
              end
            end
          end
          S_SNZ: begin
            if (dismiss) begin
              st_d[i] = S_IDLE;
            end else if (tick) begin
              // Last decrement (1 -> 0) lands back in RINGING on the same edge.
              if (snz_q[i] <= 12'd1) begin
                st_d[i]   = S_RING;
                ring_d[i] = '0;
                snz_d[i]  = '0;
              end else begin
                snz_d[i] = snz_q[i] - 12'd1;
              end
            end
          end
          default: st_d[i] = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]   <= S_IDLE;
        ring_q[i] <= '0;
        snz_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        st_q[i]   <= st_d[i];
        ring_q[i] <= ring_d[i];
        snz_q[i]  <= snz_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      ringing[i] = (st_q[i] == S_RING);
    end
  end

  logic buzz_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzz_q <= 1'b0;
    end else begin
      buzz_q <= |ringing;
    end
  end

  assign buzz = buzz_q;

  // ---------------------------------------------------------------------------
  // Time and display outputs
  // ---------------------------------------------------------------------------
  assign tsec = sec_q;
  assign tmin = min_q;
  assign thrs = hrs_q;
  assign tday = day_q;

  always_comb begin
    disp_min = min_q;
    disp_hrs = hrs_q;
    if (set_mode) begin
      disp_min = '0;
      disp_hrs = '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_sel == SEL_W'(i)) begin
          disp_min = alm_min_q[i];
          disp_hrs = alm_hrs_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

  localparam int NA    = 4;
  localparam int SNZ_T = 9 * 60;
  localparam int RING  = 60;
  localparam int WEEK  = 7 * 24 * 3600;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  logic          timeset = 1'b0, alarmset = 1'b0;
  logic          minadv = 1'b0, hrsadv = 1'b0, dayadv = 1'b0;
  logic [1:0]    alarm_sel = '0;
  logic [NA-1:0] alarm_on = '0;
  logic          dmask_wr = 1'b0;
  logic [6:0]    dmask_in = '0;
  logic          snooze = 1'b0, dismiss = 1'b0;
  logic [5:0]    tsec, tmin, disp_min;
  logic [4:0]    thrs, disp_hrs;
  logic [2:0]    tday;
  logic [NA-1:0] ringing;
  logic          buzz;

  int total = 0;
  int bad   = 0;

  multi_alarm_clock #(
    .NUM_ALARMS(NA),
    .SNOOZE_MIN(9),
    .RING_SEC(RING)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .timeset(timeset), .alarmset(alarmset),
    .minadv(minadv), .hrsadv(hrsadv), .dayadv(dayadv),
    .alarm_sel(alarm_sel), .alarm_on(alarm_on),
    .dmask_wr(dmask_wr), .dmask_in(dmask_in),
    .snooze(snooze), .dismiss(dismiss),
    .tsec(tsec), .tmin(tmin), .thrs(thrs), .tday(tday),
    .disp_min(disp_min), .disp_hrs(disp_hrs),
    .ringing(ringing), .buzz(buzz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time kept as seconds-into-week for free running; slots
  // kept as "ticks remaining" countdowns. 0 = idle, 1 = ringing, 2 = snoozed.
  // ---------------------------------------------------------------------------
  int m_sec = 0, m_min = 0, m_hrs = 0, m_day = 0;
  int m_amin [NA];
  int m_ahrs [NA];
  int m_mask [NA];
  int m_st   [NA];
  int m_left [NA];
  int m_buzz = 0;
  int tw, wrap_now, any_ring, fire;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sec = 0; m_min = 0; m_hrs = 0; m_day = 0; m_buzz = 0;
      for (int i = 0; i < NA; i++) begin
        m_amin[i] = 0; m_ahrs[i] = 0; m_mask[i] = 127; m_st[i] = 0; m_left[i] = 0;
      end
    end else begin
      any_ring = 0;
      for (int i = 0; i < NA; i++) if (m_st[i] == 1) any_ring = 1;
      wrap_now = 0;
      if (tick && !timeset && !alarmset) begin
        tw = (((m_day * 24 + m_hrs) * 60 + m_min) * 60 + m_sec + 1) % WEEK;
        m_sec = tw % 60;
        m_min = (tw / 60) % 60;
        m_hrs = (tw / 3600) % 24;
        m_day = tw / 86400;
        wrap_now = (m_sec == 0);
      end else if (tick && timeset && !alarmset) begin
        if (minadv) m_min = (m_min + 1) % 60;
        if (hrsadv) m_hrs = (m_hrs + 1) % 24;
        if (dayadv) m_day = (m_day + 1) % 7;
      end
      for (int i = 0; i < NA; i++) begin
`ifdef MULTI_ALARM_DAYMASK_EN
        fire = wrap_now && m_min == m_amin[i] && m_hrs == m_ahrs[i] && ((m_mask[i] >> m_day) & 1) == 1;
`else
        fire = wrap_now && m_min == m_amin[i] && m_hrs == m_ahrs[i];
`endif
        if (!alarm_on[i]) m_st[i] = 0;
        else if (m_st[i] == 0) begin
          if (fire) begin m_st[i] = 1; m_left[i] = RING; end
        end else if (dismiss) m_st[i] = 0;
        else if (m_st[i] == 1) begin
          if (snooze) begin m_st[i] = 2; m_left[i] = SNZ_T; end
          else if (tick) begin
            m_left[i]--;
            if (m_left[i] == 0) m_st[i] = 0;
          end
        end else if (tick) begin
          m_left[i]--;
          if (m_left[i] == 0) begin m_st[i] = 1; m_left[i] = RING; end
        end
      end
      if (tick && alarmset && !timeset) begin
        if (minadv) m_amin[alarm_sel] = (m_amin[alarm_sel] + 1) % 60;
        if (hrsadv) m_ahrs[alarm_sel] = (m_ahrs[alarm_sel] + 1) % 24;
      end
`ifdef MULTI_ALARM_DAYMASK_EN
      if (dmask_wr && alarmset && !timeset) m_mask[alarm_sel] = dmask_in;
`endif
      m_buzz = any_ring;
    end
  end

  // Per-cycle comparison against the model.
  int ev, edm, edh;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      ev = 0;
      for (int i = 0; i < NA; i++) if (m_st[i] == 1) ev |= (1 << i);
      edm = m_min; edh = m_hrs;
      if (alarmset && !timeset) begin edm = m_amin[alarm_sel]; edh = m_ahrs[alarm_sel]; end
      chk("tsec", tsec, m_sec);
      chk("tmin", tmin, m_min);
      chk("thrs", thrs, m_hrs);
      chk("tday", tday, m_day);
      chk("disp_min", disp_min, edm);
      chk("disp_hrs", disp_hrs, edh);
      chk("ringing", ringing, ev);
      chk("buzz", buzz, m_buzz);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_time(input int h, input int m, input int d);
    timeset = 1; tick = 1;
    hrsadv = 1; step((h - m_hrs + 24) % 24); hrsadv = 0;
    minadv = 1; step((m - m_min + 60) % 60); minadv = 0;
    dayadv = 1; step((d - m_day + 7) % 7);   dayadv = 0;
    timeset = 0;
    step((59 - m_sec + 60) % 60);
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  int exp_on;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tsec", tsec, 0);
    chk("rst_thrs", thrs, 0);
    chk("rst_ring", ringing, 0);
    chk("rst_buzz", buzz, 0);
    rst_n = 1;

    // One hour of free running.
    tick = 1;
    step(3600);
    chk("hr_tsec", tsec, 0);
    chk("hr_tmin", tmin, 0);
    chk("hr_thrs", thrs, 1);
    chk("hr_tday", tday, 0);
    chk("hr_buzz", buzz, 0);

    // End-of-week rollover.
    set_time(23, 59, 6);
    chk("eow_pre", {tday, thrs, tmin, tsec}, {3'd6, 5'd23, 6'd59, 6'd59});
    step(1);
    chk("eow_post", {tday, thrs, tmin, tsec}, 0);

    // Alarm 0 = 07:30.
    alarmset = 1; alarm_sel = 0;
    hrsadv = 1; step(7); hrsadv = 0;
    minadv = 1; step(30); minadv = 0;
    #1;
    chk("a0_disp", {disp_hrs, disp_min}, {5'd7, 6'd30});
    alarmset = 0;
    alarm_on = 4'b0001;
    set_time(7, 29, m_day);
    chk("a0_pre", ringing, 0);
    step(1);
    chk("a0_ring", ringing, 1);
    chk("a0_buzz0", buzz, 0);
    step(1);
    chk("a0_buzz1", buzz, 1);
    step(58);
    chk("a0_ring59", ringing, 1);
    step(1);
    chk("a0_timeout", ringing, 0);

    // Re-ring, snooze off-tick, wait out 540 ticks, then dismiss.
    set_time(7, 29, m_day);
    step(1);
    chk("sn_ring", ringing, 1);
    step(3);
    tick = 0; snooze = 1; step(1); snooze = 0;
    chk("sn_quiet", ringing, 0);
    tick = 1;
    step(539);
    chk("sn_539", ringing, 0);
    step(1);
    chk("sn_540", ringing, 1);
    tick = 0; dismiss = 1; step(1); dismiss = 0;
    chk("dis_idle", ringing, 0);
    tick = 1;
    step(200);
    chk("dis_stay", ringing, 0);

    // Alarms 1 and 2 both 06:00.
    alarm_on = 4'b0000;
    alarmset = 1;
    alarm_sel = 1; hrsadv = 1; step(6);
    alarm_sel = 2; step(6); hrsadv = 0;
    alarmset = 0;
    alarm_on = 4'b0110;
    set_time(5, 59, m_day);
    step(1);
    chk("two_ring", ringing, 4'b0110);
    alarm_on = 4'b0100;
    step(1);
    chk("one_ring", ringing, 4'b0100);

    // Display mux.
    tick = 0; alarmset = 1; alarm_sel = 2; #1;
    chk("disp_a2", {disp_hrs, disp_min}, {5'd6, 6'd0});
    alarm_sel = 0; #1;
    chk("disp_a0", {disp_hrs, disp_min}, {5'd7, 6'd30});
    timeset = 1; #1;
    chk("disp_both", {disp_hrs, disp_min}, {thrs, tmin});
    step(1);
    timeset = 0; alarmset = 0;

    // Asynchronous reset mid-ring.
    #2 rst_n = 0;
    #1;
    chk("arst_ring", ringing, 0);
    chk("arst_buzz", buzz, 0);
    chk("arst_time", {thrs, tmin}, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // Day mask: alarm 3 = 08:00, mask Mon..Fri.
    alarm_on = 4'b1000;
    alarmset = 1; alarm_sel = 3; tick = 1;
    hrsadv = 1; step(8); hrsadv = 0;
    tick = 0; dmask_in = 7'b0111110; dmask_wr = 1; step(1); dmask_wr = 0;
    alarmset = 0; tick = 1;
    for (int d = 0; d < 7; d++) begin
      set_time(7, 59, d);
      step(1);
`ifdef MULTI_ALARM_DAYMASK_EN
      exp_on = (d >= 1 && d <= 5) ? 4'b1000 : 0;
`else
      exp_on = 4'b1000;
`endif
      chk($sformatf("mask_day%0d", d), ringing, exp_on);
      tick = 0; dismiss = 1; step(1); dismiss = 0; tick = 1;
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
